// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 fixed-latency OE/WE strobe protocol.
// Serves an on-chip word array plus one I/O word at 16'hFFFF (switches in, hex display out).
module slc3_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_in,
    input  logic [15:0] Switches,
    output logic [15:0] Data_out,
    output logic        Data_valid,
    output logic [15:0] Hex_reg,
    output logic        Err
);

    localparam int          ADDR_W     = $clog2(DEPTH);
    localparam logic [15:0] IO_ADDR    = 16'hFFFF;
    // cnt value seen in the strobe cycle whose end performs the capture / commit
    localparam logic [3:0]  RD_CAP_CNT = 4'(READ_LAT - 2);
    localparam logic [3:0]  WR_CMT_CNT = 4'(WRITE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_next_cnt;
    logic [15:0]         r_addr;
    logic [15:0]         r_wdata;
    logic                r_strobe_low;
    logic [15:0]         r_mem [DEPTH];

    logic                w_start;
    logic                w_latch;
    logic                w_capture;
    logic                w_commit;
    logic                w_err;
    logic [15:0]         w_acc_addr;
    logic [15:0]         w_acc_data;
    logic [15:0]         w_rd_data;
    logic                w_is_io;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_mem_idx;

    // An access may only start from a cycle where both strobes were low,
    // so a strobe left high after an abort is ignored until it drops.
    assign w_start    = r_strobe_low & (Mem_OE | Mem_WE);

    // In cycle 1 the address/data are not yet latched, so use the live inputs.
    assign w_acc_addr = (r_state == IDLE) ? Addr    : r_addr;
    assign w_acc_data = (r_state == IDLE) ? Data_in : r_wdata;
    assign w_is_io    = (w_acc_addr == IO_ADDR);
    assign w_in_range = ((w_acc_addr >> ADDR_W) == 16'h0000);
    assign w_mem_idx  = w_acc_addr[ADDR_W-1:0];

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_is_io) begin
            w_rd_data = Switches;
        end else if (w_in_range) begin
            w_rd_data = r_mem[w_mem_idx];
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next_cnt = 4'd0;
                if (w_start) begin
                    if (Mem_OE && Mem_WE) begin
                        w_err = 1'b1;
                    end else if (Mem_OE) begin
                        w_latch    = 1'b1;
                        w_next_cnt = 4'd1;
                        if (READ_LAT == 2) begin
                            w_capture    = 1'b1;
                            w_next_state = RD_DONE;
                        end else begin
                            w_next_state = RD_WAIT;
                        end
                    end else begin
                        w_latch    = 1'b1;
                        w_next_cnt = 4'd1;
                        if (WRITE_LAT == 1) begin
                            w_commit     = 1'b1;
                            w_next_state = WR_DONE;
                        end else begin
                            w_next_state = WR_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (Mem_WE || !Mem_OE) begin
                    w_err        = Mem_WE;
                    w_next_cnt   = 4'd0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + 4'd1;
                    if (r_cnt == RD_CAP_CNT) begin
                        w_capture    = 1'b1;
                        w_next_state = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                if (Mem_WE || !Mem_OE) begin
                    w_err        = Mem_WE;
                    w_next_cnt   = 4'd0;
                    w_next_state = IDLE;
                end
            end
            WR_WAIT: begin
                if (Mem_OE || !Mem_WE) begin
                    w_err        = Mem_OE;
                    w_next_cnt   = 4'd0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + 4'd1;
                    if (r_cnt == WR_CMT_CNT) begin
                        w_commit     = 1'b1;
                        w_next_state = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                if (Mem_OE || !Mem_WE) begin
                    w_err        = Mem_OE;
                    w_next_cnt   = 4'd0;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_cnt   = 4'd0;
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_strobe_low <= 1'b0;
            Data_out     <= 16'h0000;
            Data_valid   <= 1'b0;
            Hex_reg      <= 16'h0000;
            Err          <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_strobe_low <= !Mem_OE && !Mem_WE;
            Err          <= w_err;
            Data_valid   <= (w_next_state == RD_DONE);
            if (w_latch) begin
                r_addr  <= Addr;
                r_wdata <= Data_in;
            end
            if (w_capture) begin
                Data_out <= w_rd_data;
            end
            if (w_commit && w_is_io) begin
                Hex_reg <= w_acc_data;
            end
        end
    end

    // NOTE: the storage array has no reset; Reset only blocks an in-flight commit.
    always_ff @(posedge Clk) begin
        if (!Reset && w_commit && !w_is_io && w_in_range) begin
            r_mem[w_mem_idx] <= w_acc_data;
        end
    end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Scoreboard bench for slc3_mem_responder: directed accesses push expected reads/errors,
// an independent negedge monitor pops and compares when Data_valid rises or Err pulses.
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Addr;
    logic [15:0] Data_in;
    logic [15:0] Switches;
    logic [15:0] Data_out;
    logic        Data_valid;
    logic [15:0] Hex_reg;
    logic        Err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] rd_q[$];
    int          err_pending = 0;
    logic [15:0] hex_model = 16'h0000;
    logic        mon_prev_valid = 1'b0;
    logic        mon_prev_err = 1'b0;
    logic [15:0] mon_exp;

    slc3_mem_responder #(
        .DEPTH(256),
        .READ_LAT(3),
        .WRITE_LAT(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Mem_OE(Mem_OE),
        .Mem_WE(Mem_WE),
        .Addr(Addr),
        .Data_in(Data_in),
        .Switches(Switches),
        .Data_out(Data_out),
        .Data_valid(Data_valid),
        .Hex_reg(Hex_reg),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT presents a response.
    always @(negedge Clk) begin
        if (Reset) begin
            mon_prev_valid <= 1'b0;
            mon_prev_err   <= 1'b0;
        end else begin
            if (Data_valid && !mon_prev_valid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_valid", {15'd0, Data_valid}, 16'h0000);
                end else begin
                    mon_exp = rd_q.pop_front();
                    check("read_data", Data_out, mon_exp);
                end
            end
            if (Err) begin
                if (mon_prev_err) begin
                    check("err_width", {15'd0, Err}, 16'h0000);
                end else if (err_pending == 0) begin
                    check("unexpected_err", {15'd0, Err}, 16'h0000);
                end else begin
                    err_pending--;
                    check("err_pulse", {15'd0, Err}, 16'h0001);
                end
            end
            mon_prev_valid <= Data_valid;
            mon_prev_err   <= Err;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        repeat (n) cyc();
    endtask

    // 3-cycle read; Addr is scrambled after cycle 1 to confirm it was latched.
    task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
        Addr   = a;
        Mem_OE = 1'b1;
        rd_q.push_back(exp);
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clk);
            check($sformatf("rd_valid_c%0d_%h", c, a), {15'd0, Data_valid},
                  (c == 3) ? 16'h0001 : 16'h0000);
            cyc();
            if (c == 1) Addr = ~a;
        end
        Mem_OE = 1'b0;
        cyc();
        @(negedge Clk);
        check($sformatf("rd_valid_drop_%h", a), {15'd0, Data_valid}, 16'h0000);
        cyc();
    endtask

    // n-cycle write; Addr/Data_in are scrambled after cycle 1 to confirm latching.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int n);
        Addr    = a;
        Data_in = d;
        Mem_WE  = 1'b1;
        for (int c = 1; c <= n; c++) begin
            cyc();
            if (c == 1) begin
                Addr    = ~a;
                Data_in = ~d;
            end
        end
        Mem_WE = 1'b0;
        if (a == 16'hFFFF && n >= 3) hex_model = d;
        @(negedge Clk);
        check($sformatf("hex_reg_after_wr_%h", a), Hex_reg, hex_model);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        Mem_OE   = 1'b0;
        Mem_WE   = 1'b0;
        Addr     = 16'h0000;
        Data_in  = 16'h0000;
        Switches = 16'h0000;
        repeat (3) cyc();
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_data_out", Data_out, 16'h0000);
        check("reset_valid", {15'd0, Data_valid}, 16'h0000);
        check("reset_hex", Hex_reg, 16'h0000);
        check("reset_err", {15'd0, Err}, 16'h0000);
        cyc();

        // Basic read of a preloaded word
        do_write(16'h0010, 16'h1234, 3);
        do_read(16'h0010, 16'h1234);

        // Write then read back; long WE hold must still commit once with latched data
        do_write(16'h0020, 16'hBEEF, 3);
        do_read(16'h0020, 16'hBEEF);
        do_write(16'h0020, 16'hBEEF, 5);
        do_read(16'h0020, 16'hBEEF);

        // Short WE is an aborted write
        do_write(16'h0020, 16'h0000, 2);
        do_read(16'h0020, 16'hBEEF);

        // I/O word, aliasing and out-of-range accesses
        Switches = 16'hA5A5;
        do_write(16'h00FF, 16'h7777, 3);
        do_read(16'hFFFF, 16'hA5A5);
        do_write(16'hFFFF, 16'h00C3, 3);
        do_read(16'h00FF, 16'h7777);
        do_write(16'h0110, 16'h9999, 3);
        do_read(16'h0110, 16'h0000);
        do_read(16'h0010, 16'h1234);

        // Both strobes in IDLE
        err_pending++;
        Addr    = 16'h0020;
        Data_in = 16'h0000;
        Mem_OE  = 1'b1;
        Mem_WE  = 1'b1;
        cyc();
        idle(3);
        do_read(16'h0020, 16'hBEEF);

        // WE rising in OE cycle 2; both stay high one extra cycle and must be ignored
        err_pending++;
        Addr    = 16'h0020;
        Data_in = 16'h0000;
        Mem_OE  = 1'b1;
        cyc();
        Mem_WE  = 1'b1;
        cyc();
        cyc();
        idle(2);
        do_read(16'h0020, 16'hBEEF);

        // Reset in WE cycle 2 (held through what would be the commit cycle)
        do_write(16'h0030, 16'h3333, 3);
        Addr    = 16'h0030;
        Data_in = 16'hDEAD;
        Mem_WE  = 1'b1;
        cyc();
        Reset = 1'b1;
        cyc();
        cyc();
        Mem_WE = 1'b0;
        @(negedge Clk);
        check("rst_mid_hex", Hex_reg, 16'h0000);
        check("rst_mid_valid", {15'd0, Data_valid}, 16'h0000);
        check("rst_mid_err", {15'd0, Err}, 16'h0000);
        cyc();
        Reset     = 1'b0;
        hex_model = 16'h0000;
        idle(2);
        do_read(16'h0030, 16'h3333);

        idle(3);
        check("reads_outstanding", 16'(rd_q.size()), 16'h0000);
        check("errs_outstanding", 16'(err_pending), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
